// File: rtl/bcd_up_down_counter_nd.sv
// Multi-digit BCD up/down counter with synchronous load, count enable and
// wrap/saturate limit handling; registered carry/borrow/load_err strobes.
module bcd_up_down_counter_nd #(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  enable,
    input  logic                  down_up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err,
    output logic                  is_max,
    output logic                  is_zero
);

    logic [4*DIGITS-1:0] r_count;
    logic                r_carry;
    logic                r_borrow;
    logic                r_load_err;

    // w_all9[k] / w_all0[k]: every digit below k is 9 / 0 (ripple enables)
    logic [DIGITS:0]     w_all9;
    logic [DIGITS:0]     w_all0;
    logic [DIGITS-1:0]   w_dig_ok;
    logic [4*DIGITS-1:0] w_step_raw;
    logic [4*DIGITS-1:0] w_step;
    logic                w_load_ok;
    logic                w_at_max;
    logic                w_at_zero;
    logic                w_at_limit;

    assign w_all9[0] = 1'b1;
    assign w_all0[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_dig;
            logic [3:0] w_dig_next;

            assign w_dig          = r_count[4*gi +: 4];
            assign w_all9[gi+1]   = w_all9[gi] & (w_dig == 4'd9);
            assign w_all0[gi+1]   = w_all0[gi] & (w_dig == 4'd0);
            assign w_dig_ok[gi]   = (load_value[4*gi +: 4] <= 4'd9);

            always_comb begin
                w_dig_next = w_dig;
                if (!down_up) begin
                    if (w_all9[gi]) begin
                        w_dig_next = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
                    end
                end else begin
                    if (w_all0[gi]) begin
                        w_dig_next = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
                    end
                end
            end

            assign w_step_raw[4*gi +: 4] = w_dig_next;
        end
    endgenerate

    assign w_load_ok  = &w_dig_ok;
    assign w_at_max   = w_all9[DIGITS];
    assign w_at_zero  = w_all0[DIGITS];
    assign w_at_limit = down_up ? w_at_zero : w_at_max;

    // Raw ripple already wraps 9..9 <-> 0..0; saturation simply holds instead
    generate
        if (SATURATE != 0) begin : g_sat
            assign w_step = w_at_limit ? r_count : w_step_raw;
        end else begin : g_wrap
            assign w_step = w_step_raw;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_count <= load_value;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (enable) begin
                r_count  <= w_step;
                r_carry  <= ~down_up & w_at_max;
                r_borrow <= down_up & w_at_zero;
            end
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign load_err = r_load_err;
    assign is_max   = w_at_max;
    assign is_zero  = w_at_zero;

endmodule
